io_port_bridge: RTL

- Sits between the processor's ALU I/O ports and an external byte-wide device.
- It is the far end of the OUT/IN instructions:
  - Values the processor writes with OUT go into a small TX FIFO, which drains to the device over a valid/ready handshake.
  - Bytes from the device are captured into a one-entry RX holding register, which drives the ALU's inPort until an IN instruction consumes them.
- Status outputs let software poll occupancy and detect lost or stale data.

---
 rtl/io_pkg.sv | 11 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/io_port_bridge.sv | 99 +++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the I/O port bridge: default data width and RX state encoding.
package io_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic {
    RX_EMPTY = 1'b0,
    RX_FULL  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. A push into a full FIFO is accepted when a pop
// happens in the same cycle, so a full queue can stream at one byte per cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count,
  output logic                  push_dropped
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; count gates whether any entry is meaningful.
  always_ff @(posedge clock) begin
    if (reset_n && do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data     = mem_q[rd_ptr_q];
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign push_dropped = push && !do_push;

endmodule

// File: rtl/io_port_bridge.sv
// Far end of the OUT/IN instructions: TX FIFO toward the device, one-entry RX
// holding register toward the ALU, plus sticky overflow/underflow flags.
module io_port_bridge
  import io_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TX_DEPTH   = 4,
  parameter int TX_AW      = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] outPort,
  input  logic                  out_strobe,
  input  logic                  in_strobe,
  input  logic                  flags_clear,
  output logic [DATA_WIDTH-1:0] inPort,
  output logic                  rx_full,
  output logic [TX_AW:0]        tx_count,
  output logic                  tx_overflow,
  output logic                  rx_underflow,
  output logic [DATA_WIDTH-1:0] dev_tx_data,
  output logic                  dev_tx_valid,
  input  logic                  dev_tx_ready,
  input  logic [DATA_WIDTH-1:0] dev_rx_data,
  input  logic                  dev_rx_valid,
  output logic                  dev_rx_ready
);

  logic tx_full, tx_empty, tx_dropped;

  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (TX_DEPTH)
  ) u_tx_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push        (out_strobe),
    .push_data   (outPort),
    .pop         (dev_tx_ready),
    .pop_data    (dev_tx_data),
    .full        (tx_full),
    .empty       (tx_empty),
    .count       (tx_count),
    .push_dropped(tx_dropped)
  );

  assign dev_tx_valid = !tx_empty;

  rx_state_e             rx_state_q, rx_state_d;
  logic [DATA_WIDTH-1:0] inport_q, inport_d;
  logic                  tx_overflow_q, tx_overflow_d;
  logic                  rx_underflow_q, rx_underflow_d;
  logic                  rx_capture, rx_underflow_evt;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_state_q     <= RX_EMPTY;
      inport_q       <= '0;
      tx_overflow_q  <= 1'b0;
      rx_underflow_q <= 1'b0;
    end else begin
      rx_state_q     <= rx_state_d;
      inport_q       <= inport_d;
      tx_overflow_q  <= tx_overflow_d;
      rx_underflow_q <= rx_underflow_d;
    end
  end

  // Next state
  always_comb begin
    rx_state_d = rx_state_q;
    inport_d   = inport_q;
    case (rx_state_q)
      RX_EMPTY: if (rx_capture) begin
        rx_state_d = RX_FULL;
        inport_d   = dev_rx_data;
      end
      RX_FULL: if (in_strobe) rx_state_d = RX_EMPTY;
      default: rx_state_d = RX_EMPTY;
    endcase
    // A set event outranks a simultaneous clear.
    tx_overflow_d  = tx_dropped || (tx_overflow_q && !flags_clear);
    rx_underflow_d = rx_underflow_evt || (rx_underflow_q && !flags_clear);
  end

  // Outputs
  always_comb begin
    dev_rx_ready     = reset_n && (rx_state_q == RX_EMPTY);
    rx_full          = (rx_state_q == RX_FULL);
    rx_capture       = (rx_state_q == RX_EMPTY) && dev_rx_valid;
    rx_underflow_evt = (rx_state_q == RX_EMPTY) && in_strobe;
  end

  assign inPort       = inport_q;
  assign tx_overflow  = tx_overflow_q;
  assign rx_underflow = rx_underflow_q;

endmodule
